lsu_mem_ctrl: RTL and testbench

- Single-outstanding memory access sequencer behind the LSU issue queue.
- Accepts one awakened load/store uop at a time from the queue's awake outputs and back-pressures the queue with stall_lsuq.
- Reads store data from the PRF, drives a req/gnt/rvalid data-memory port, and aligns and extends load data.
- Broadcasts completion (data, Pd, ROB tag, exception) on the LSU's dedicated CDB slot.

---
 rtl/lsu_mem_ctrl.sv | 119 +++++++++++
 tb/tb_lsu_mem_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store sequencer between the LSU queue, data memory and the LSU CDB slot.
module lsu_mem_ctrl #(
    parameter int PRF_AW = 6,
    parameter int ROB_TW = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ready_awake,
    input  logic [PRF_AW-1:0] Px_awake,
    input  logic [31:0]       Addr_awake,
    input  logic [3:0]        Conf_awake,
    input  logic              RegWr_awake,
    input  logic [ROB_TW-1:0] tag_rob_awake,
    input  logic              has_excp_awake,
    output logic              stall_lsuq,
    output logic [PRF_AW-1:0] prf_raddr,
    input  logic [31:0]       prf_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              ready_cdb_lsu,
    output logic              RegWr_cdb_lsu,
    output logic [PRF_AW-1:0] Pd_cdb_lsu,
    output logic [31:0]       data_cdb_lsu,
    output logic [ROB_TW-1:0] tag_rob_cdb_lsu,
    output logic              excp_cdb_lsu
);
    typedef enum logic [2:0] {IDLE, REQ, RESP, WB, DRAIN} state_t;
    state_t            state;
    logic [PRF_AW-1:0] px_q;
    logic [ROB_TW-1:0] tag_q;
    logic [29:0]       waddr_q;
    logic [1:0]        off_q, size_q;
    logic              zext_q, regwr_q, excp_q, wb, misalign, unused_conf;
    logic [31:0]       ld_data, ld_sh, ld_val, wdat;
    logic [15:0]       ld_h;
    logic [3:0]        strb;

    assign unused_conf = Conf_awake[3];
    assign prf_raddr   = Px_awake;
    assign stall_lsuq  = (state != IDLE) || ready_awake;
    assign mem_addr    = {waddr_q, 2'b00};

    assign misalign = (Conf_awake[1:0] == 2'b10 && Addr_awake[1:0] != 2'b00) ||
                      (Conf_awake[1:0] == 2'b01 && Addr_awake[0]) || Conf_awake[1:0] == 2'b11;
    assign strb = Conf_awake[1:0] == 2'b00 ? 4'b0001 << Addr_awake[1:0] :
                  Conf_awake[1:0] == 2'b01 ? (Addr_awake[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdat = Conf_awake[1:0] == 2'b00 ? {4{prf_rdata[7:0]}} :
                  Conf_awake[1:0] == 2'b01 ? {2{prf_rdata[15:0]}} : prf_rdata;

    assign ld_sh  = mem_rdata >> {off_q, 3'b000};
    assign ld_h   = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign ld_val = size_q == 2'b00 ? {{24{~zext_q & ld_sh[7]}}, ld_sh[7:0]} :
                    size_q == 2'b01 ? {{16{~zext_q & ld_h[15]}}, ld_h} : mem_rdata;

    // A flush landing in the WB cycle must squash the broadcast in that same cycle.
    assign wb              = (state == WB) && !flush;
    assign ready_cdb_lsu   = wb;
    assign RegWr_cdb_lsu   = wb && regwr_q && !excp_q;
    assign Pd_cdb_lsu      = wb ? px_q : '0;
    assign tag_rob_cdb_lsu = wb ? tag_q : '0;
    assign excp_cdb_lsu    = wb && excp_q;
    assign data_cdb_lsu    = RegWr_cdb_lsu ? ld_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            px_q      <= '0;
            tag_q     <= '0;
            waddr_q   <= '0;
            off_q     <= '0;
            size_q    <= '0;
            zext_q    <= 1'b0;
            regwr_q   <= 1'b0;
            excp_q    <= 1'b0;
            ld_data   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (ready_awake && !flush) begin
                    px_q      <= Px_awake;
                    tag_q     <= tag_rob_awake;
                    waddr_q   <= Addr_awake[31:2];
                    off_q     <= Addr_awake[1:0];
                    size_q    <= Conf_awake[1:0];
                    zext_q    <= Conf_awake[2];
                    regwr_q   <= RegWr_awake;
                    excp_q    <= has_excp_awake || misalign;
                    ld_data   <= '0;
                    mem_we    <= !RegWr_awake;
                    mem_wstrb <= RegWr_awake ? 4'b0000 : strb;
                    mem_wdata <= RegWr_awake ? 32'h0 : wdat;
                    mem_req   <= !(has_excp_awake || misalign);
                    state     <= (has_excp_awake || misalign) ? WB : REQ;
                end
                REQ: if (flush || mem_gnt) begin
                    mem_req <= 1'b0;
                    state   <= flush ? (mem_gnt ? DRAIN : IDLE) : RESP;
                end
                RESP: if (mem_rvalid) begin
                    ld_data <= ld_val;
                    state   <= flush ? IDLE : WB;
                end else if (flush) state <= DRAIN;
                WB:      state <= IDLE;
                DRAIN:   if (mem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: scenario tasks drive uops and a scripted memory; a CDB monitor pops a scoreboard of expected broadcasts.
module tb_lsu_mem_ctrl;
    localparam int PRF_AW = 6;
    localparam int ROB_TW = 6;

    logic clk = 0, rst = 1, flush = 0, ready_awake = 0, RegWr_awake = 0, has_excp_awake = 0;
    logic mem_gnt = 0, mem_rvalid = 0;
    logic [PRF_AW-1:0] Px_awake = '0;
    logic [31:0] Addr_awake = '0, prf_rdata = '0, mem_rdata = '0;
    logic [3:0] Conf_awake = '0;
    logic [ROB_TW-1:0] tag_rob_awake = '0;
    logic stall_lsuq, mem_req, mem_we, ready_cdb_lsu, RegWr_cdb_lsu, excp_cdb_lsu;
    logic [PRF_AW-1:0] prf_raddr, Pd_cdb_lsu;
    logic [31:0] mem_addr, mem_wdata, data_cdb_lsu;
    logic [3:0] mem_wstrb;
    logic [ROB_TW-1:0] tag_rob_cdb_lsu;

    typedef struct packed {
        logic              regwr;
        logic [PRF_AW-1:0] pd;
        logic [31:0]       data;
        logic [ROB_TW-1:0] tag;
        logic              excp;
    } cdb_t;
    cdb_t exp_q[$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.PRF_AW(PRF_AW), .ROB_TW(ROB_TW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ready_awake(ready_awake), .Px_awake(Px_awake),
        .Addr_awake(Addr_awake), .Conf_awake(Conf_awake), .RegWr_awake(RegWr_awake),
        .tag_rob_awake(tag_rob_awake), .has_excp_awake(has_excp_awake), .stall_lsuq(stall_lsuq),
        .prf_raddr(prf_raddr), .prf_rdata(prf_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ready_cdb_lsu(ready_cdb_lsu),
        .RegWr_cdb_lsu(RegWr_cdb_lsu), .Pd_cdb_lsu(Pd_cdb_lsu), .data_cdb_lsu(data_cdb_lsu),
        .tag_rob_cdb_lsu(tag_rob_cdb_lsu), .excp_cdb_lsu(excp_cdb_lsu)
    );

    // CDB monitor: every pulse must match the oldest expected result; idle cycles must be all-zero.
    always @(negedge clk) if (!rst) begin
        cdb_t got, want;
        got = '{RegWr_cdb_lsu, Pd_cdb_lsu, data_cdb_lsu, tag_rob_cdb_lsu, excp_cdb_lsu};
        if (ready_cdb_lsu) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cdb_unexpected: got pulse regwr=%0b pd=%0d data=%h tag=%0d excp=%0b, expected no pulse",
                         got.regwr, got.pd, got.data, got.tag, got.excp);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL cdb_result: got regwr=%0b pd=%0d data=%h tag=%0d excp=%0b, expected regwr=%0b pd=%0d data=%h tag=%0d excp=%0b",
                             got.regwr, got.pd, got.data, got.tag, got.excp,
                             want.regwr, want.pd, want.data, want.tag, want.excp);
                end
            end
        end else if (got !== '0) begin
            errors++;
            $display("FAIL cdb_idle: got %h outside a pulse, expected 0", got);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ld_model(input logic [31:0] r, input logic [1:0] off, input logic [3:0] conf);
        logic [7:0] b;
        logic [15:0] h;
        case (off)
            2'd0: b = r[7:0];
            2'd1: b = r[15:8];
            2'd2: b = r[23:16];
            default: b = r[31:24];
        endcase
        h = off[1] ? r[31:16] : r[15:0];
        case (conf[1:0])
            2'b00: return conf[2] ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01: return conf[2] ? {16'h0, h} : {{16{h[15]}}, h};
            default: return r;
        endcase
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [PRF_AW-1:0] px, input logic [31:0] addr, input logic [3:0] conf,
                         input logic regwr, input logic [ROB_TW-1:0] tag, input logic hx, input logic [31:0] pd);
        ready_awake = 1; Px_awake = px; Addr_awake = addr; Conf_awake = conf;
        RegWr_awake = regwr; tag_rob_awake = tag; has_excp_awake = hx; prf_rdata = pd;
        @(negedge clk);
        checks++;
        if (stall_lsuq !== 1'b1 || prf_raddr !== px) begin
            errors++;
            $display("FAIL issue_cycle: stall=%0b raddr=%0d, expected stall=1 raddr=%0d", stall_lsuq, prf_raddr, px);
        end
        step();
        ready_awake = 0; has_excp_awake = 0;
    endtask

    task automatic serve(input int gwait, input logic we, input logic [31:0] maddr, input logic [3:0] strb,
                         input logic [31:0] wd, input logic [31:0] rd);
        for (int i = 0; i <= gwait; i++) begin
            mem_gnt = (i == gwait);
            @(negedge clk);
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, stall_lsuq} !== {1'b1, we, maddr, strb, wd, 1'b1}) begin
                errors++;
                $display("FAIL req_payload: got req=%0b we=%0b addr=%h strb=%b wdata=%h stall=%0b, expected req=1 we=%0b addr=%h strb=%b wdata=%h stall=1",
                         mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, stall_lsuq, we, maddr, strb, wd);
            end
            step();
        end
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = rd;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || stall_lsuq !== 1'b1) begin
            errors++;
            $display("FAIL resp_wait: got req=%0b stall=%0b, expected req=0 stall=1", mem_req, stall_lsuq);
        end
        step();
        mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic expect_drained(input string name);
        step(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d CDB results missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1;
        step(2);
        @(negedge clk);
        checks++;
        if ({stall_lsuq, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, ready_cdb_lsu, RegWr_cdb_lsu,
             Pd_cdb_lsu, data_cdb_lsu, tag_rob_cdb_lsu, excp_cdb_lsu} !== '0) begin
            errors++;
            $display("FAIL reset_state: req=%0b stall=%0b addr=%h cdb=%0b, expected all 0", mem_req, stall_lsuq, mem_addr, ready_cdb_lsu);
        end
        rst = 0;
        step();
    endtask

    task automatic test_word_load();
        issue(5, 32'h1000, 4'b0010, 1, 9, 0, 32'h0);
        exp_q.push_back('{1'b1, 6'd5, 32'hDEADBEEF, 6'd9, 1'b0});
        serve(0, 0, 32'h1000, 4'b0000, 32'h0, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if (ready_cdb_lsu !== 1'b1 || stall_lsuq !== 1'b1) begin
            errors++;
            $display("FAIL word_load_latency: cdb=%0b stall=%0b at t+3, expected 1 1", ready_cdb_lsu, stall_lsuq);
        end
        step();
        @(negedge clk);
        checks++;
        if (stall_lsuq !== 1'b0) begin
            errors++;
            $display("FAIL word_load_release: stall=%0b at t+4, expected 0", stall_lsuq);
        end
        expect_drained("word_load");
    endtask

    task automatic test_sub_word_loads();
        issue(1, 32'h1003, 4'b0000, 1, 2, 0, 32'h0);
        exp_q.push_back('{1'b1, 6'd1, 32'hFFFFFF80, 6'd2, 1'b0});
        serve(0, 0, 32'h1000, 4'b0000, 32'h0, 32'h80112233);
        step();
        issue(1, 32'h1003, 4'b0100, 1, 3, 0, 32'h0);
        exp_q.push_back('{1'b1, 6'd1, 32'h00000080, 6'd3, 1'b0});
        serve(0, 0, 32'h1000, 4'b0000, 32'h0, 32'h80112233);
        step();
        for (int i = 0; i < 8; i++) begin
            logic [1:0] off;
            logic [3:0] conf;
            logic [31:0] rd;
            conf = {1'b0, i[0], 1'b0, i[1]};
            off = i[1] ? {i[2], 1'b0} : {i[2], i[0]};
            rd = $urandom();
            issue(6'(10 + i), 32'h3000 | {30'h0, off}, conf, 1, 6'(20 + i), 0, 32'h0);
            exp_q.push_back('{1'b1, 6'(10 + i), ld_model(rd, off, conf), 6'(20 + i), 1'b0});
            serve(i % 3, 0, 32'h3000, 4'b0000, 32'h0, rd);
            step();
        end
        expect_drained("sub_word_loads");
    endtask

    task automatic test_stores();
        issue(3, 32'h2002, 4'b0001, 0, 4, 0, 32'h0000ABCD);
        exp_q.push_back('{1'b0, 6'd3, 32'h0, 6'd4, 1'b0});
        serve(0, 1, 32'h2000, 4'b1100, 32'hABCDABCD, 32'hFFFFFFFF);
        step();
        issue(8, 32'h2001, 4'b0000, 0, 5, 0, 32'h12345678);
        exp_q.push_back('{1'b0, 6'd8, 32'h0, 6'd5, 1'b0});
        serve(1, 1, 32'h2000, 4'b0010, 32'h78787878, 32'h0);
        step();
        issue(9, 32'h2004, 4'b0010, 0, 6, 0, 32'h12345678);
        exp_q.push_back('{1'b0, 6'd9, 32'h0, 6'd6, 1'b0});
        serve(5, 1, 32'h2004, 4'b1111, 32'h12345678, 32'h0);
        expect_drained("stores");
    endtask

    task automatic test_exceptions();
        logic [31:0] addrs [4] = '{32'h1001, 32'h1000, 32'h1003, 32'h1000};
        logic [3:0]  confs [4] = '{4'b0010, 4'b0010, 4'b0001, 4'b0011};
        logic        hxs   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            issue(6'(7 + i), addrs[i], confs[i], 1, 6'(11 + i), hxs[i], 32'h0);
            exp_q.push_back('{1'b0, 6'(7 + i), 32'h0, 6'(11 + i), 1'b1});
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || ready_cdb_lsu !== 1'b1 || excp_cdb_lsu !== 1'b1) begin
                errors++;
                $display("FAIL excp_path_%0d: req=%0b cdb=%0b excp=%0b at t+1, expected 0 1 1", i, mem_req, ready_cdb_lsu, excp_cdb_lsu);
            end
            step();
        end
        expect_drained("exceptions");
    endtask

    task automatic test_flush_resp();
        issue(12, 32'h1000, 4'b0010, 1, 13, 0, 32'h0);
        mem_gnt = 1;
        step();
        mem_gnt = 0; flush = 1;
        step();
        flush = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (stall_lsuq !== 1'b1 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL flush_resp_drain_%0d: stall=%0b req=%0b, expected 1 0", i, stall_lsuq, mem_req);
            end
            step();
        end
        mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        checks++;
        if (stall_lsuq !== 1'b1) begin
            errors++;
            $display("FAIL flush_resp_rvalid: stall=%0b, expected 1", stall_lsuq);
        end
        step();
        mem_rvalid = 0;
        @(negedge clk);
        checks++;
        if (stall_lsuq !== 1'b0) begin
            errors++;
            $display("FAIL flush_resp_release: stall=%0b, expected 0", stall_lsuq);
        end
        step();
        issue(14, 32'h1004, 4'b0010, 1, 15, 0, 32'h0);
        exp_q.push_back('{1'b1, 6'd14, 32'h01020304, 6'd15, 1'b0});
        serve(0, 0, 32'h1004, 4'b0000, 32'h0, 32'h01020304);
        expect_drained("flush_resp_next");
    endtask

    task automatic test_flush_req();
        issue(16, 32'h4000, 4'b0010, 1, 17, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            flush = (i == 2);
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h4000) begin
                errors++;
                $display("FAIL gnt_stall_%0d: req=%0b addr=%h, expected 1 00004000", i, mem_req, mem_addr);
            end
            step();
        end
        flush = 0;
        mem_rvalid = 1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || stall_lsuq !== 1'b0) begin
            errors++;
            $display("FAIL flush_req: req=%0b stall=%0b, expected 0 0", mem_req, stall_lsuq);
        end
        step();
        mem_rvalid = 0;
        issue(18, 32'h4000, 4'b0010, 1, 19, 0, 32'h0);
        mem_gnt = 1; flush = 1;
        step();
        mem_gnt = 0; flush = 0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || stall_lsuq !== 1'b1) begin
            errors++;
            $display("FAIL flush_req_gnt: req=%0b stall=%0b, expected 0 1", mem_req, stall_lsuq);
        end
        mem_rvalid = 1;
        step();
        mem_rvalid = 0;
        @(negedge clk);
        checks++;
        if (stall_lsuq !== 1'b0) begin
            errors++;
            $display("FAIL flush_req_gnt_release: stall=%0b, expected 0", stall_lsuq);
        end
        step();
        expect_drained("flush_req");
    endtask

    task automatic test_flush_idle_wb();
        flush = 1;
        issue(20, 32'h1000, 4'b0010, 1, 21, 0, 32'h0);
        flush = 0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || stall_lsuq !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: req=%0b stall=%0b, expected 0 0", mem_req, stall_lsuq);
        end
        step();
        issue(22, 32'h1002, 4'b0010, 1, 23, 0, 32'h0);
        flush = 1;
        @(negedge clk);
        checks++;
        if (ready_cdb_lsu !== 1'b0) begin
            errors++;
            $display("FAIL flush_wb: cdb=%0b, expected 0", ready_cdb_lsu);
        end
        step();
        flush = 0;
        @(negedge clk);
        checks++;
        if (stall_lsuq !== 1'b0) begin
            errors++;
            $display("FAIL flush_wb_idle: stall=%0b, expected 0", stall_lsuq);
        end
        step();
        expect_drained("flush_idle_wb");
    endtask

    task automatic test_reset_mid();
        issue(24, 32'h1000, 4'b0010, 1, 25, 0, 32'h0);
        mem_gnt = 1;
        step();
        mem_gnt = 0; rst = 1;
        step();
        rst = 0; mem_rvalid = 1;
        @(negedge clk);
        checks++;
        if (stall_lsuq !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: stall=%0b req=%0b, expected 0 0", stall_lsuq, mem_req);
        end
        step();
        mem_rvalid = 0;
        expect_drained("reset_mid");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            logic [31:0] rd;
            rd = $urandom();
            issue(6'(30 + i), 32'h5000 + 32'(4 * i), 4'b0010, 1, 6'(40 + i), 0, 32'h0);
            exp_q.push_back('{1'b1, 6'(30 + i), rd, 6'(40 + i), 1'b0});
            serve(0, 0, 32'h5000 + 32'(4 * i), 4'b0000, 32'h0, rd);
            step();
        end
        expect_drained("back_to_back");
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_sub_word_loads();
        test_stores();
        test_exceptions();
        test_flush_resp();
        test_flush_req();
        test_flush_idle_wb();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
